// File: rtl/ic_pkg.sv
// Shared types and helpers for discrete-IC emulation models.
// Holds the one-shot state enum, a complementary-output pair and counter sizing.
package ic_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } os_state_e;

    typedef struct packed {
        logic q;
        logic q_n;
    } cmp_out_t;

    // Bits needed to hold a down-counter that starts at n-1; never zero-width.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// One-bit edge detector producing single-cycle rise/fall strobes from the registered previous value.
// Latency: strobes are combinational on d against last cycle's sample; no backpressure.
// Reset loads the current input so a static level never reads as an edge after release.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= d;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;
    assign fall = ~d & prev_q;

endmodule

// File: rtl/clocked_one_shot.sv
// Synchronous 74121/9602-style one-shot: Q high for PULSE_LEN cycles from the edge sampling a trigger.
// Latency: Q/Q_N registered, one edge after the trigger is presented; no backpressure.
// Define CLOCKED_ONE_SHOT_RETRIGGER_EN for retriggerable (9602) behaviour; default is non-retriggerable (74121).
module clocked_one_shot
    import ic_pkg::*;
#(
    parameter int PULSE_LEN = 16
) (
    input  logic CLK_DRV,
    input  logic RESET,
    input  logic A_N,
    input  logic B,
    input  logic CLR_N,
    output logic Q,
    output logic Q_N
);

    localparam int              CNT_W  = cnt_width(PULSE_LEN);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_LEN - 1);

    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;
    logic unused_strobes;

    edge_detect u_edge_a (
        .clk  (CLK_DRV),
        .rst  (RESET),
        .d    (A_N),
        .rise (a_rise),
        .fall (a_fall)
    );

    edge_detect u_edge_b (
        .clk  (CLK_DRV),
        .rst  (RESET),
        .d    (B),
        .rise (b_rise),
        .fall (b_fall)
    );

    assign unused_strobes = a_rise | b_fall;

    os_state_e        state_q;
    os_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    cmp_out_t         out_q;
    cmp_out_t         out_d;
    logic             trig;
    logic             accept;

    always_comb begin
        trig    = (a_fall & B) | (b_rise & ~A_N);
`ifdef CLOCKED_ONE_SHOT_RETRIGGER_EN
        accept  = trig;
`else
        // A trigger arriving while the pulse runs, even on its last cycle, is dropped.
        accept  = trig & (state_q == IDLE);
`endif
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!CLR_N) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = ACTIVE;
            cnt_d   = RELOAD;
        end else if (state_q == ACTIVE) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                state_d = IDLE;
            end
        end
        out_d.q   = (state_d == ACTIVE);
        out_d.q_n = (state_d != ACTIVE);
    end

    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '{q: 1'b0, q_n: 1'b1};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign Q   = out_q.q;
    assign Q_N = out_q.q_n;

endmodule

// File: tb/tb_clocked_one_shot.sv
// Bench for clocked_one_shot at PULSE_LEN=4 and PULSE_LEN=1 sharing one stimulus stream.
// Expected outputs come from a remaining-cycles model and are checked by a separate monitor.
module tb_clocked_one_shot;

`ifdef CLOCKED_ONE_SHOT_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk;
    logic rst;
    logic a_n;
    logic b;
    logic clr_n;
    logic q4, qn4, q1, qn1;

    clocked_one_shot #(.PULSE_LEN(4)) dut4 (
        .CLK_DRV (clk), .RESET (rst), .A_N (a_n), .B (b), .CLR_N (clr_n),
        .Q (q4), .Q_N (qn4)
    );

    clocked_one_shot #(.PULSE_LEN(1)) dut1 (
        .CLK_DRV (clk), .RESET (rst), .A_N (a_n), .B (b), .CLR_N (clr_n),
        .Q (q1), .Q_N (qn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit q4;
        bit q1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    // Model state: cycles of high output still owed, plus last sampled inputs.
    int rem4 = 0;
    int rem1 = 0;
    bit pa   = 1'b1;
    bit pb   = 1'b0;

    function automatic int next_rem(int rem, int len, bit r, bit clr, bit trg);
        if (r || !clr) return 0;
        if (trg && (rem == 0 || RETRIG)) return len;
        if (rem > 0) return rem - 1;
        return 0;
    endfunction

    // Apply inputs for the coming edge and record what that edge must produce.
    task automatic drive(input bit r, input bit an, input bit bb, input bit clr);
        bit   trg;
        exp_t e;
        rst   = r;
        a_n   = an;
        b     = bb;
        clr_n = clr;
        trg   = (pa && !an && bb) || (!pb && bb && !an);
        rem4  = next_rem(rem4, 4, r, clr, trg);
        rem1  = next_rem(rem1, 1, r, clr, trg);
        pa    = an;
        pb    = bb;
        e.q4  = (rem4 > 0);
        e.q1  = (rem1 > 0);
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit an, input bit bb, input bit clr);
        @(posedge clk);
        #1;
        drive(r, an, bb, clr);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(1'b0, a_n, b, clr_n);
    endtask

    task automatic check(input string name, input bit act, input bit req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    // Monitor: every edge presents fresh outputs; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("q_len4",   q4,  e.q4);
                check("qn_len4",  qn4, !e.q4);
                check("q_len1",   q1,  e.q1);
                check("qn_len1",  qn1, !e.q1);
            end
        end
    end

    initial begin
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        // Reset held with A_N low and B high: static levels must not fire on release.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        hold(3);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        hold(6);

        // B rise with A_N low, second rise two cycles later.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        hold(2);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        hold(7);

        // Clear during a pulse, trigger while cleared, release on static inputs.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        hold(5);

        // Reset mid-pulse with a simultaneous trigger.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        hold(5);

        // A_N toggling every cycle with B high; also retriggers/expiry collisions at length 4.
        for (int i = 0; i < 12; i++) step(1'b0, i[0], 1'b1, 1'b1);
        hold(6);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) == 0),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 11) != 0));
        end

        hold(2);
        @(posedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
